input_skew_buffer: RTL and testbench

- Parametrised successor of the systolic-array input skewing stage.
- Takes one row-vector per accepted beat and delays lane i so the vector enters the PE array as a diagonal wavefront.
- Supports full-array mode and 2-tile mode; the 2-tile mode doubles input throughput by skewing two half-vectors independently.
- Adds a valid/ready handshake, per-lane valid tracking and a drain state machine so a mode change never corrupts in-flight data.

---
 rtl/input_skew_buffer.sv | 147 ++++++++++++++
 tb/tb_input_skew_buffer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/input_skew_buffer.sv
// input_skew_buffer: per-lane delay lines that skew a row vector into a diagonal wavefront.
// Full-array or 2-tile mode, drain FSM on mode change; INPUT_SKEW_PERF_EN adds accept/drain counters.
`default_nettype none

module input_skew_buffer #(
  parameter int SIZE       = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tile_req,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SIZE*DATA_WIDTH-1:0] in_0,
  input  logic [SIZE*DATA_WIDTH-1:0] in_1,
  output logic [SIZE*DATA_WIDTH-1:0] out_data,
  output logic [SIZE-1:0]            out_valid,
  output logic                       tile_mode,
  output logic                       busy
`ifdef INPUT_SKEW_PERF_EN
  ,
  output logic [31:0]                accept_cnt,
  output logic [31:0]                drain_cnt
`endif
);

  localparam int HALF = SIZE / 2;
  localparam int CW   = (SIZE > 2) ? $clog2(SIZE) : 1;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t        state;
  logic [CW-1:0] drain_left;
  logic          accept;

  assign in_ready = (state == ST_RUN) && (tile_req == tile_mode);
  assign accept   = in_valid && in_ready;

  // Upper half of vector B never carries data in either mode.
  logic unused_in_1;
  assign unused_in_1 = ^in_1[SIZE*DATA_WIDTH-1:HALF*DATA_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      drain_left <= '0;
      busy       <= 1'b0;
      tile_mode  <= tile_req;
    end else begin
      case (state)
        ST_RUN: begin
          if (tile_req != tile_mode) begin
            state      <= ST_DRAIN;
            busy       <= 1'b1;
            drain_left <= tile_mode ? CW'(HALF - 1) : CW'(SIZE - 1);
          end
        end
        ST_DRAIN: begin
          if (drain_left == '0) begin
            state     <= ST_RUN;
            busy      <= 1'b0;
            tile_mode <= tile_req;
          end else begin
            drain_left <= drain_left - 1'b1;
          end
        end
        default: begin
          state <= ST_RUN;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  genvar i;
  generate
    for (i = 0; i < SIZE; i++) begin : g_lane
      localparam bit TILE_LANE = (i >= HALF);

      logic [DATA_WIDTH-1:0] dq [0:i];
      logic                  vq [0:i];
      logic [DATA_WIDTH-1:0] d0;
      logic                  v0;
      logic [DATA_WIDTH-1:0] d1;
      logic                  v1;

      assign v0 = accept && !(tile_mode && TILE_LANE);
      assign d0 = v0 ? in_0[DATA_WIDTH*i +: DATA_WIDTH] : '0;

      if (TILE_LANE) begin : g_tile_src
        assign v1 = accept && tile_mode;
        assign d1 = v1 ? in_1[DATA_WIDTH*(i-HALF) +: DATA_WIDTH] : '0;
      end else begin : g_no_tile_src
        assign v1 = 1'b0;
        assign d1 = '0;
      end

      // Tile lanes inject vector B part-way down the chain so the shorter delay
      // still ends at the same output register; the stages above it carry zeros.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k <= i; k++) begin
            dq[k] <= '0;
            vq[k] <= 1'b0;
          end
        end else begin
          dq[0] <= d0;
          vq[0] <= v0;
          for (int k = 1; k <= i; k++) begin
            if (TILE_LANE && tile_mode && (k == HALF)) begin
              dq[k] <= d1;
              vq[k] <= v1;
            end else begin
              dq[k] <= dq[k-1];
              vq[k] <= vq[k-1];
            end
          end
        end
      end

      assign out_data[DATA_WIDTH*i +: DATA_WIDTH] = dq[i];
      assign out_valid[i]                         = vq[i];
    end
  endgenerate

`ifdef INPUT_SKEW_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      accept_cnt <= '0;
      drain_cnt  <= '0;
    end else begin
      if (accept && (accept_cnt != '1)) begin
        accept_cnt <= accept_cnt + 1'b1;
      end
      if ((state == ST_DRAIN) && (drain_cnt != '1)) begin
        drain_cnt <= drain_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_input_skew_buffer.sv
// Directed bench for input_skew_buffer (SIZE=8, DATA_WIDTH=8).
`default_nettype none

module tb_input_skew_buffer;

  localparam int SIZE = 8;
  localparam int DW   = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 tile_req;
  logic                 in_valid;
  logic                 in_ready;
  logic [SIZE*DW-1:0]   in_0;
  logic [SIZE*DW-1:0]   in_1;
  logic [SIZE*DW-1:0]   out_data;
  logic [SIZE-1:0]      out_valid;
  logic                 tile_mode;
  logic                 busy;
`ifdef INPUT_SKEW_PERF_EN
  logic [31:0]          accept_cnt;
  logic [31:0]          drain_cnt;
`endif

  int tests  = 0;
  int failed = 0;

  logic [SIZE*DW-1:0] exp_d;
  logic [SIZE-1:0]    exp_v;
  logic [SIZE*DW-1:0] vec_a;

  input_skew_buffer #(.SIZE(SIZE), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .tile_req  (tile_req),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_0      (in_0),
    .in_1      (in_1),
    .out_data  (out_data),
    .out_valid (out_valid),
    .tile_mode (tile_mode),
    .busy      (busy)
`ifdef INPUT_SKEW_PERF_EN
    ,
    .accept_cnt(accept_cnt),
    .drain_cnt (drain_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst      = 1'b1;
    tile_req = 1'b0;
    in_valid = 1'b0;
    in_0     = '0;
    in_1     = '0;
    vec_a    = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    tick;
    tick;
    rst = 1'b0;

    // Reset state
    chk("rst_out_data", 64'(out_data), 64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_tile_mode", 64'(tile_mode), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h1);

    // Single full-mode beat: diagonal with lane i = i+1 after edge i
    in_0 = vec_a;
    for (int n = 0; n <= 8; n++) begin
      in_valid = (n == 0);
      tick;
      exp_d = '0;
      exp_v = '0;
      if (n < 8) begin
        exp_d[8*n +: 8] = 8'(n + 1);
        exp_v[n]        = 1'b1;
      end
      chk("full_single_data", 64'(out_data), 64'(exp_d));
      chk("full_single_valid", 64'(out_valid), 64'(exp_v));
    end

    // Beats at edges 0,1,3 with a bubble at edge 2
    for (int n = 0; n <= 11; n++) begin
      in_valid = (n == 0) || (n == 1) || (n == 3);
      tick;
      exp_d = '0;
      exp_v = '0;
      for (int i = 0; i < SIZE; i++) begin
        if ((n - i == 0) || (n - i == 1) || (n - i == 3)) begin
          exp_d[8*i +: 8] = 8'(i + 1);
          exp_v[i]        = 1'b1;
        end
      end
      chk("b2b_data", 64'(out_data), 64'(exp_d));
      chk("b2b_valid", 64'(out_valid), 64'(exp_v));
    end
    in_valid = 1'b0;

    // Full -> tile switch with one beat in flight
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tile_req = 1'b1;
    #1;
    chk("sw_req_in_ready", 64'(in_ready), 64'h0);
    chk("sw_req_busy", 64'(busy), 64'h0);
    for (int n = 1; n <= 9; n++) begin
      tick;
      exp_d = '0;
      exp_v = '0;
      if (n < 8) begin
        exp_d[8*n +: 8] = 8'(n + 1);
        exp_v[n]        = 1'b1;
      end
      chk("drain_data", 64'(out_data), 64'(exp_d));
      chk("drain_valid", 64'(out_valid), 64'(exp_v));
      if (n <= 8) begin
        chk("drain_busy", 64'(busy), 64'h1);
        chk("drain_in_ready", 64'(in_ready), 64'h0);
        chk("drain_tile_mode", 64'(tile_mode), 64'h0);
      end else begin
        chk("post_drain_busy", 64'(busy), 64'h0);
        chk("post_drain_tile_mode", 64'(tile_mode), 64'h1);
        chk("post_drain_in_ready", 64'(in_ready), 64'h1);
      end
    end

    // Brief tile_req glitch between edges causes no drain
    tile_req = 1'b0;
    #2;
    tile_req = 1'b1;
    tick;
    chk("glitch_busy", 64'(busy), 64'h0);
    chk("glitch_in_ready", 64'(in_ready), 64'h1);

    // Tile mode, two beats; in_0 upper lanes must never appear
    in_0 = {8'h99, 8'h99, 8'h99, 8'h99, 8'd4, 8'd3, 8'd2, 8'd1};
    in_1 = {8'h77, 8'h77, 8'h77, 8'h77, 8'd44, 8'd33, 8'd22, 8'd11};
    for (int n = 0; n <= 5; n++) begin
      in_valid = (n == 0) || (n == 1);
      tick;
      exp_d = '0;
      exp_v = '0;
      for (int i = 0; i < SIZE / 2; i++) begin
        if ((n - i == 0) || (n - i == 1)) begin
          exp_d[8*i +: 8]       = 8'(i + 1);
          exp_d[8*(i + 4) +: 8] = 8'(11 * (i + 1));
          exp_v[i]              = 1'b1;
          exp_v[i + 4]          = 1'b1;
        end
      end
      chk("tile_data", 64'(out_data), 64'(exp_d));
      chk("tile_valid", 64'(out_valid), 64'(exp_v));
    end
    in_valid = 1'b0;

`ifdef INPUT_SKEW_PERF_EN
    chk("perf_accept_cnt", 64'(accept_cnt), 64'd7);
    chk("perf_drain_cnt", 64'(drain_cnt), 64'd8);
`endif

    // Reset in the middle of a tile -> full drain
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tile_req = 1'b0;
    tick;
    chk("mid_drain_busy", 64'(busy), 64'h1);
    chk("mid_drain_valid", 64'(out_valid), 64'h22);
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst_drain_valid", 64'(out_valid), 64'h0);
    chk("rst_drain_data", 64'(out_data), 64'h0);
    chk("rst_drain_busy", 64'(busy), 64'h0);
    chk("rst_drain_in_ready", 64'(in_ready), 64'h1);
    chk("rst_drain_tile_mode", 64'(tile_mode), 64'h0);
`ifdef INPUT_SKEW_PERF_EN
    chk("perf_rst_accept_cnt", 64'(accept_cnt), 64'd0);
    chk("perf_rst_drain_cnt", 64'(drain_cnt), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
